// File: rtl/ms13_master_sink_pkg.sv
// Shared types for the TestMasterSlave13 master-port sink.
package ms13_sink_types;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } sink_state_t;

  localparam int MS13_WORD_W = 32;

endpackage

// File: rtl/ms13_sync_fifo.sv
// Synchronous FIFO with a registered occupancy counter and a non-fall-through head.
module ms13_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ms13_master_sink.sv
// Buffers master-port notify words, drains them over ready/valid and keeps statistics.
module ms13_master_sink
  import ms13_sink_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MS13_WORD_W-1:0] m_in,
  input  logic                   m_in_notify,
  input  logic                   clr,
  output logic [MS13_WORD_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW:0]            fill_level,
  output logic                   overflow,
  output logic [MS13_WORD_W-1:0] count_out,
  output logic [MS13_WORD_W-1:0] sum_out,
  output sink_state_t            state_out
);

  localparam logic [AW:0] LAST_FREE = 
    (AW+1)'(DEPTH - 1);

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        drop;
  sink_state_t state_next;

  // clr wins over everything, so a word arriving with clr is neither stored nor counted.
  assign pop       = out_valid && out_ready && !clr;
  assign push      = m_in_notify && (!full || pop) && !clr;
  assign drop      = m_in_notify && full && !pop && !clr;
  assign out_valid = !empty;

  ms13_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (MS13_WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wr_data (m_in),
    .rd_data (out_data),
    .level   (fill_level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_out <= '0;
      sum_out   <= '0;
      overflow  <= 1'b0;
      state_out <= ST_EMPTY;
    end else if (clr) begin
      count_out <= '0;
      sum_out   <= '0;
      overflow  <= 1'b0;
      state_out <= ST_EMPTY;
    end else begin
      if (push) begin
        count_out <= count_out + 1'b1;
        sum_out   <= sum_out + m_in;
      end
      if (drop) overflow <= 1'b1;
      state_out <= state_next;
    end
  end

  always_comb begin
    state_next = state_out;
    case (state_out)
      ST_EMPTY: begin
        if (push) state_next = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && fill_level == LAST_FREE) state_next = ST_FULL;
        else if (pop && !push && fill_level == (AW+1)'(1)) state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop && !push) state_next = ST_PARTIAL;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_ms13_master_sink.sv
// Directed and randomized checks of ms13_master_sink against a queue-based reference model.
module tb_ms13_master_sink;
  import ms13_sink_types::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        m_in = '0;
  logic               m_in_notify = 1'b0;
  logic               clr = 1'b0;
  logic [31:0]        out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [AW:0]        fill_level;
  logic               overflow;
  logic [31:0]        count_out;
  logic [31:0]        sum_out;
  sink_state_t        state_out;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mq[$];
  logic [31:0] m_count;
  logic [31:0] m_sum;
  logic        m_ovf;

  always #5 clk = ~clk;

  ms13_master_sink #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_in        (m_in),
    .m_in_notify (m_in_notify),
    .clr         (clr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .count_out   (count_out),
    .sum_out     (sum_out),
    .state_out   (state_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_count = '0;
    m_sum   = '0;
    m_ovf   = 1'b0;
  endtask

  // One clock of the sink's rules, evaluated on the inputs present before the edge.
  task automatic modelStep(input bit notify, input logic [31:0] data, input bit ready, input bit c);
    bit do_pop;
    if (c) begin
      modelReset();
      return;
    end
    do_pop = (mq.size() > 0) && ready;
    if (do_pop) void'(mq.pop_front());
    if (notify) begin
      if (mq.size() < DEPTH) begin
        mq.push_back(data);
        m_count = m_count + 1;
        m_sum   = m_sum + data;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    sink_state_t exp_state;
    if (mq.size() == 0)          exp_state = ST_EMPTY;
    else if (mq.size() == DEPTH) exp_state = ST_FULL;
    else                         exp_state = ST_PARTIAL;
    check("out_valid",  32'(out_valid),  32'(mq.size() != 0));
    check("out_data",   out_data,        (mq.size() != 0) ? mq[0] : 32'h0);
    check("fill_level", 32'(fill_level), 32'(mq.size()));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("count_out",  count_out,       m_count);
    check("sum_out",    sum_out,         m_sum);
    check("state_out",  32'(state_out),  32'(exp_state));
  endtask

  task automatic applyStimulus(input bit notify, input logic [31:0] data, input bit ready, input bit c);
    m_in_notify = notify;
    m_in        = data;
    out_ready   = ready;
    clr         = c;
    modelStep(notify, data, ready, c);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [31:0] held;
    modelReset();
    #12;
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Three words with the consumer stalled, then drained in order
    applyStimulus(1, 32'd5, 0, 0);
    held = out_data;
    applyStimulus(1, -32'sd3, 0, 0);
    check("head_stable", out_data, held);
    applyStimulus(1, 32'd7, 0, 0);
    check("sum_5_m3_7", sum_out, 32'd9);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
    check("drained_state", 32'(state_out), 32'(ST_EMPTY));

    // Overfill by one
    applyStimulus(0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) applyStimulus(1, 32'(i), 0, 0);
    check("ovf_count", count_out, 32'd4);
    check("ovf_sum", sum_out, 32'd10);
    check("ovf_flag", 32'(overflow), 32'd1);

    // Full with simultaneous push and pop
    applyStimulus(0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) applyStimulus(1, 32'(i), 0, 0);
    applyStimulus(1, 32'd9, 1, 0);
    check("full_pushpop_level", 32'(fill_level), 32'd4);
    check("full_pushpop_ovf", 32'(overflow), 32'd0);

    // Sum wraps through the sign boundary
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 32'h7FFF_FFFF, 1, 0);
    applyStimulus(1, 32'd1, 1, 0);
    check("sum_wrap", sum_out, 32'h8000_0000);

    // clr beats a same-cycle notify and pop
    applyStimulus(1, 32'd42, 1, 1);
    check("clr_level", 32'(fill_level), 32'd0);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 300; i++) begin
      applyStimulus(bit'($urandom_range(0, 3) != 0), $urandom(),
                    bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 40) == 0));
    end

    // Reset mid-burst takes effect without waiting for a clock
    for (int i = 0; i < 3; i++) applyStimulus(1, $urandom(), 0, 0);
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput();
    m_in_notify = 1'b0;
    out_ready   = 1'b0;
    clr         = 1'b0;
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b1;
    applyStimulus(1, 32'd11, 0, 0);
    applyStimulus(0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
